spi_master_tx: RTL and testbench

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 38 +++
 rtl/spi_master_tx.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI master transmitter.
// Build option: define SPI_TX_LATCH_PULSE_EN to add the LATCH state.
// LATCH sends one extra sclk pulse with ss high after each frame.
package spi_pkg;

  // Default generics for the transmitter.
  localparam int SPI_DEF_CLK_DIV = 4;
  localparam int SPI_DEF_DATA_W  = 8;

  // SPI mode 0: sclk idles low, data sampled on rising edge.
  localparam int SPI_CPOL = 0;
  localparam int SPI_CPHA = 0;

  // Derived line levels.
  localparam logic SPI_SCLK_IDLE = (SPI_CPOL != 0);
  localparam logic SPI_SS_IDLE   = 1'b1;

  // The half-period divider counts up to 255, so 8 bits are enough.
  localparam int SPI_DIV_W = 8;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3
`ifdef SPI_TX_LATCH_PULSE_EN
    , ST_LATCH = 3'd4
`endif
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI master.
// The counter runs 0..CLK_DIV-1 while enabled and emits a one-cycle tick on
// the terminal count. A synchronous clear puts the count back to 0, so every
// state starts a full half-period. No free-running divider is used.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [SPI_DIV_W-1:0] TERM = SPI_DIV_W'(CLK_DIV - 1);

  logic [SPI_DIV_W-1:0] r_cnt;
  logic                 w_term;

  assign w_term = (r_cnt == TERM);
  assign o_tick = i_en & w_term;

  // Half-period counter. Reset or clear wins; otherwise wrap at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_term) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: single-word SPI master transmitter (mode 0, MSB first).
// Frame: LEAD (ss low, sclk low), SHIFT (2*DATA_W half-periods starting
// high), TRAIL (sclk low, ss low), then back to IDLE with a done pulse.
// Build option: define SPI_TX_LATCH_PULSE_EN to add a LATCH state after
// TRAIL. LATCH raises ss, then sends one sclk pulse so the slave can capture
// its parallel output. done is then raised on LATCH -> IDLE.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_DEF_CLK_DIV,  // clk cycles per sclk half-period, 1..255
  parameter int DATA_W  = SPI_DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  output logic              busy,
  output logic              done
);

  // Half-period index inside SHIFT/LATCH. Wide enough for 2*DATA_W.
  localparam int HALF_W = $clog2(2 * DATA_W + 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);
  // Half that ends with the final falling edge. mosi holds here, it does not shift.
  localparam logic [HALF_W-1:0] LAST_FALL = HALF_W'(2 * DATA_W - 2);
  // CPHA=0: data moves on the edge that leaves sclk's active (high) level.
  localparam logic SHIFT_ON_FALL = (SPI_CPHA == 0);
`ifdef SPI_TX_LATCH_PULSE_EN
  // LATCH is three half-periods: low (settle after ss rise), high, low.
  localparam logic [HALF_W-1:0] LATCH_LAST = HALF_W'(2);
`endif

  spi_state_e        r_state;
  spi_state_e        w_state_next;
  logic              w_tick;
  logic              w_clr;
  logic              w_en;
  logic              w_ready;
  logic              w_ss;
  logic              r_sclk;
  logic              r_done;
  logic [DATA_W-1:0] r_shift;
  logic [HALF_W-1:0] r_half;

  // The divider runs only inside a frame and restarts on every state change.
  assign w_en  = (r_state != ST_IDLE);
  assign w_clr = (w_state_next != r_state);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // State register. Reset returns to IDLE from anywhere and overrides tx_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. tx_valid is only looked at in IDLE, so there is no queuing.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_state_next = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (w_tick) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick && (r_half == LAST_HALF)) begin
          w_state_next = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (w_tick) begin
`ifdef SPI_TX_LATCH_PULSE_EN
          w_state_next = ST_LATCH;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
`ifdef SPI_TX_LATCH_PULSE_EN
      ST_LATCH: begin
        if (w_tick && (r_half == LATCH_LAST)) begin
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs: ready only in IDLE, ss active across LEAD/SHIFT/TRAIL.
  always_comb begin
    w_ready = 1'b0;
    w_ss    = SPI_SS_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
      end
      ST_LEAD, ST_SHIFT, ST_TRAIL: begin
        w_ss = ~SPI_SS_IDLE;
      end
      default: begin
        w_ss = SPI_SS_IDLE;
      end
    endcase
  end

  // Serial datapath: load on accept, toggle sclk on ticks, shift on falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk  <= SPI_SCLK_IDLE;
      r_shift <= '0;
      r_half  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_shift <= tx_data;
            r_sclk  <= SPI_SCLK_IDLE;
            r_half  <= '0;
          end
        end
        ST_LEAD: begin
          // First sclk edge of the frame is a rising edge.
          if (w_tick) begin
            r_sclk <= ~SPI_SCLK_IDLE;
            r_half <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_half == LAST_HALF) begin
              r_sclk <= SPI_SCLK_IDLE;
              r_half <= '0;
            end else begin
              r_sclk <= ~r_sclk;
              r_half <= r_half + 1'b1;
              // Do not shift on the last fall, so mosi holds bit 0 through TRAIL.
              if ((r_sclk == SHIFT_ON_FALL) && (r_half != LAST_FALL)) begin
                r_shift <= r_shift << 1;
              end
            end
          end
        end
        ST_TRAIL: begin
          if (w_tick) begin
            r_shift <= '0;
            r_half  <= '0;
`ifndef SPI_TX_LATCH_PULSE_EN
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef SPI_TX_LATCH_PULSE_EN
        ST_LATCH: begin
          if (w_tick) begin
            if (r_half == LATCH_LAST) begin
              r_done <= 1'b1;
              r_half <= '0;
              r_sclk <= SPI_SCLK_IDLE;
            end else begin
              r_half <= r_half + 1'b1;
              r_sclk <= (r_half == '0) ? ~SPI_SCLK_IDLE : SPI_SCLK_IDLE;
            end
          end
        end
`endif
        default: begin
          r_half <= '0;
        end
      endcase
    end
  end

  assign tx_ready = w_ready;
  assign busy     = ~w_ready;
  assign ss       = w_ss;
  assign sclk     = r_sclk;
  assign mosi     = r_shift[DATA_W-1];
  assign done     = r_done;

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed, table-driven bench for spi_master_tx.
// It runs three instances with CLK_DIV = 4, 1 and 2.
// A negedge monitor per instance acts as an SPI slave receiver.
// It shifts mosi in on rising sclk while ss is low and latches the parallel word on rising sclk while ss is high.
// It also watches the mode-0 line rules.
`timescale 1ns/1ps
module tb_spi_master_tx;

  localparam int NDUT = 3;
  localparam int NVEC = 9;
`ifdef SPI_TX_LATCH_PULSE_EN
  localparam int EXP_LATCH = 1;
`else
  localparam int EXP_LATCH = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst, tx_valid, tx_ready, sclk, ss, mosi, busy, done;
  logic [7:0]      tx_data [NDUT];

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    spi_master_tx #(
      .CLK_DIV ((gi == 0) ? 4 : ((gi == 1) ? 1 : 2)),
      .DATA_W  (8)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[gi]),
      .tx_data  (tx_data[gi]),
      .tx_valid (tx_valid[gi]),
      .tx_ready (tx_ready[gi]),
      .sclk     (sclk[gi]),
      .ss       (ss[gi]),
      .mosi     (mosi[gi]),
      .busy     (busy[gi]),
      .done     (done[gi])
    );
  end

  // Slave-receiver / protocol monitor state.
  int unsigned viol        [NDUT] = '{default: 0};
  int unsigned done_cnt    [NDUT] = '{default: 0};
  int unsigned latch_cnt   [NDUT] = '{default: 0};
  int unsigned ss_low_cnt  [NDUT] = '{default: 0};
  int unsigned last_ss_low [NDUT] = '{default: 0};
  logic [7:0]  cap_word    [NDUT] = '{default: 8'h00};
  logic [7:0]  last_word   [NDUT] = '{default: 8'h00};
  logic [7:0]  rx_par      [NDUT] = '{default: 8'h00};
  logic [NDUT-1:0] p_sclk = '0, p_ss = '1, p_mosi = '0;

  // Monitor: slave shift/latch model, ss-low length, done count, line rules.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if ((ss[i] !== p_ss[i]) && (sclk[i] !== 1'b0)) begin
        viol[i] <= viol[i] + 1;
        $display("FAIL sclk_at_ss_edge dut%0d t=%0t: sclk=%b, required 0", i, $time, sclk[i]);
      end
      if ((mosi[i] !== p_mosi[i]) && (sclk[i] !== 1'b0)) begin
        viol[i] <= viol[i] + 1;
        $display("FAIL mosi_while_sclk_high dut%0d t=%0t: mosi changed with sclk=%b, required 0", i, $time, sclk[i]);
      end
      if (!ss[i] && p_ss[i]) begin
        ss_low_cnt[i] <= 1;
        cap_word[i]   <= 8'h00;
      end else if (!ss[i]) begin
        ss_low_cnt[i] <= ss_low_cnt[i] + 1;
      end
      if (ss[i] && !p_ss[i]) begin
        last_ss_low[i] <= ss_low_cnt[i];
        last_word[i]   <= cap_word[i];
      end
      if (sclk[i] && !p_sclk[i]) begin
        if (!ss[i]) begin
          cap_word[i] <= {cap_word[i][6:0], mosi[i]};
        end else begin
          latch_cnt[i] <= latch_cnt[i] + 1;
          rx_par[i]    <= cap_word[i];
        end
      end
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
      end
      p_sclk[i] <= sclk[i];
      p_ss[i]   <= ss[i];
      p_mosi[i] <= mosi[i];
    end
  end

  int n_applied     = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h, required 0x%0h", name, dut, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    for (int k = 0; k < 1000; k++) begin
      if (tx_ready[d]) return;
      tick();
    end
    check("ready_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int d);
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (done[d]) return;
    end
    check("done_timeout", d, 32'd0, 32'd1);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [7:0] exp_word;
    logic       exp_msb;
    int         exp_ss_low;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic run_vector(input int idx, input vec_t v);
    int unsigned done0, latch0;
    int d;
    d      = v.dut;
    wait_ready(d);
    done0  = done_cnt[d];
    latch0 = latch_cnt[d];
    tx_data[d]  = v.data;
    tx_valid[d] = 1'b1;
    tick();
    tx_valid[d] = 1'b0;
    check("lead_ss", d, 32'(ss[d]), 32'd0);
    check("lead_sclk", d, 32'(sclk[d]), 32'd0);
    check("lead_mosi", d, 32'(mosi[d]), 32'(v.exp_msb));
    check("lead_ready", d, 32'(tx_ready[d]), 32'd0);
    check("lead_busy", d, 32'(busy[d]), 32'd1);
    wait_done(d);
    check("done_ss", d, 32'(ss[d]), 32'd1);
    check("done_ready", d, 32'(tx_ready[d]), 32'd1);
    check("done_mosi", d, 32'(mosi[d]), 32'd0);
    check("done_sclk", d, 32'(sclk[d]), 32'd0);
    @(negedge clk);
    #1;
    check("rx_word", d, 32'(last_word[d]), 32'(v.exp_word));
    check("ss_low_len", d, last_ss_low[d], 32'(v.exp_ss_low));
    repeat (3) tick();
    check("done_pulses", d, done_cnt[d] - done0, 32'd1);
    check("latch_pulses", d, latch_cnt[d] - latch0, 32'(EXP_LATCH));
`ifdef SPI_TX_LATCH_PULSE_EN
    check("rx_parallel", d, 32'(rx_par[d]), 32'(v.exp_word));
`endif
    $display("vec %0d dut%0d data=%02h rx=%02h ss_low=%0d", idx, d, v.data, last_word[d], last_ss_low[d]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned done0;
    int rises;
    logic prev;

    rst = '1;
    tx_valid = '0;
    for (int i = 0; i < NDUT; i++) tx_data[i] = 8'h00;
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      check("rst_ss", i, 32'(ss[i]), 32'd1);
      check("rst_sclk", i, 32'(sclk[i]), 32'd0);
      check("rst_mosi", i, 32'(mosi[i]), 32'd0);
      check("rst_ready", i, 32'(tx_ready[i]), 32'd1);
      check("rst_busy", i, 32'(busy[i]), 32'd0);
      check("rst_done", i, 32'(done[i]), 32'd0);
    end
    rst = '0;
    tick();

    // dut, data, expected received word, expected first mosi, expected ss-low cycles
    vecs[0] = '{0, 8'hA5, 8'hA5, 1'b1, 72};
    vecs[1] = '{0, 8'h00, 8'h00, 1'b0, 72};
    vecs[2] = '{0, 8'hFF, 8'hFF, 1'b1, 72};
    vecs[3] = '{0, 8'h5A, 8'h5A, 1'b0, 72};
    vecs[4] = '{1, 8'h01, 8'h01, 1'b0, 18};
    vecs[5] = '{1, 8'h80, 8'h80, 1'b1, 18};
    vecs[6] = '{1, 8'hC3, 8'hC3, 1'b1, 18};
    vecs[7] = '{2, 8'h5A, 8'h5A, 1'b0, 36};
    vecs[8] = '{2, 8'h96, 8'h96, 1'b1, 36};
    for (int v = 0; v < NVEC; v++) run_vector(v, vecs[v]);

    // Back-to-back frames on CLK_DIV=1 with tx_valid held high.
    wait_ready(1);
    tx_data[1]  = 8'h00;
    tx_valid[1] = 1'b1;
    tick();
    check("b2b_first_lead_ss", 1, 32'(ss[1]), 32'd0);
    tx_data[1] = 8'hFF;
    wait_done(1);
    check("b2b_gap_ss", 1, 32'(ss[1]), 32'd1);
    check("b2b_gap_ready", 1, 32'(tx_ready[1]), 32'd1);
    tick();
    tx_valid[1] = 1'b0;
    check("b2b_second_lead_ss", 1, 32'(ss[1]), 32'd0);
    check("b2b_second_mosi", 1, 32'(mosi[1]), 32'd1);
    check("b2b_first_word", 1, 32'(last_word[1]), 32'h00);
    check("b2b_first_ss_low", 1, last_ss_low[1], 32'd18);
    wait_done(1);
    @(negedge clk);
    #1;
    check("b2b_second_word", 1, 32'(last_word[1]), 32'hFF);
    check("b2b_second_ss_low", 1, last_ss_low[1], 32'd18);
    $display("seq b2b dut1 frames 00,FF rx=%02h", last_word[1]);

    // tx_valid pulsed mid-frame must be ignored.
    wait_ready(0);
    done0 = done_cnt[0];
    tx_data[0]  = 8'h81;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    repeat (20) tick();
    tx_data[0]  = 8'h3C;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    check("ignore_busy", 0, 32'(busy[0]), 32'd1);
    wait_done(0);
    @(negedge clk);
    #1;
    check("ignore_word", 0, 32'(last_word[0]), 32'h81);
    repeat (6) tick();
    check("ignore_no_queue_ss", 0, 32'(ss[0]), 32'd1);
    check("ignore_no_queue_ready", 0, 32'(tx_ready[0]), 32'd1);
    check("ignore_done_pulses", 0, done_cnt[0] - done0, 32'd1);
    $display("seq ignore dut0 sent 81 pulsed 3C rx=%02h", last_word[0]);

    // Reset at the 4th rising sclk of 8'hC3, with tx_valid high in the same cycle.
    wait_ready(0);
    done0 = done_cnt[0];
    tx_data[0]  = 8'hC3;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    rises = 0;
    prev  = sclk[0];
    for (int k = 0; k < 500; k++) begin
      tick();
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
      if (rises == 4) break;
    end
    check("rst_mid_rise4", 0, 32'(rises), 32'd4);
    rst[0]      = 1'b1;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h55;
    tick();
    rst[0]      = 1'b0;
    tx_valid[0] = 1'b0;
    check("rst_mid_ss", 0, 32'(ss[0]), 32'd1);
    check("rst_mid_sclk", 0, 32'(sclk[0]), 32'd0);
    check("rst_mid_mosi", 0, 32'(mosi[0]), 32'd0);
    check("rst_mid_ready", 0, 32'(tx_ready[0]), 32'd1);
    check("rst_mid_busy", 0, 32'(busy[0]), 32'd0);
    check("rst_mid_done", 0, 32'(done[0]), 32'd0);
    repeat (60) tick();
    check("rst_mid_no_done", 0, done_cnt[0] - done0, 32'd0);
    check("rst_mid_idle_ss", 0, 32'(ss[0]), 32'd1);
    $display("seq reset dut0 frame C3 cut at rise %0d", rises);

    for (int i = 0; i < NDUT; i++) check("line_rules", i, viol[i], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
